// File: rtl/inst_queue_dual.sv
// inst_queue_dual: dual-port instruction queue between fetch and decode/issue.
// Accepts 0-2 lines per cycle from fetch and presents the two oldest entries
// to a dual-issue decoder, which pops 0-2 of them per cycle in program order.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   ib_flush          synchronous flush, overrides push/pop
//   ib_wr_num         lines pushed (0..2), ib_wr_line0 older, ib_wr_line1 younger
//   ib_rd_num         lines popped (0..2)
//   ib_rline0/1       entries at head and head+1
//   ib_rvalid0/1      occupancy >= 1 / >= 2
//   ib_count          occupancy 0..DEPTH
//   ib_empty/full     occupancy == 0 / == DEPTH
//   ib_afull          fewer than two free slots
//   ib_err            registered one-cycle pulse after an illegal request
module inst_queue_dual #(
  parameter int DEPTH   = 16,
  parameter int EXC_WD  = 3,
  localparam int LINE_WD = 64 + EXC_WD,
  localparam int AW      = $clog2(DEPTH),
  localparam int CNT_WD  = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ib_flush,
  input  logic [1:0]         ib_wr_num,
  input  logic [LINE_WD-1:0] ib_wr_line0,
  input  logic [LINE_WD-1:0] ib_wr_line1,
  input  logic [1:0]         ib_rd_num,
  output logic [LINE_WD-1:0] ib_rline0,
  output logic [LINE_WD-1:0] ib_rline1,
  output logic               ib_rvalid0,
  output logic               ib_rvalid1,
  output logic [CNT_WD-1:0]  ib_count,
  output logic               ib_empty,
  output logic               ib_full,
  output logic               ib_afull,
  output logic               ib_err
);

  logic [LINE_WD-1:0] mem [DEPTH];
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic [CNT_WD-1:0]  count;

  logic [CNT_WD-1:0]  free_slots;
  logic               wr_ok;
  logic               rd_ok;
  logic [1:0]         wr_amt;
  logic [1:0]         rd_amt;
  logic               err_nxt;

  // Legality is judged against the current occupancy only; a same-cycle pop
  // never makes room for a same-cycle push.
  always_comb begin
    free_slots = CNT_WD'(DEPTH) - count;
    wr_ok      = (ib_wr_num != 2'd3) && (CNT_WD'(ib_wr_num) <= free_slots);
    rd_ok      = (ib_rd_num != 2'd3) && (CNT_WD'(ib_rd_num) <= count);
    wr_amt     = wr_ok ? ib_wr_num : 2'd0;
    rd_amt     = rd_ok ? ib_rd_num : 2'd0;
    err_nxt    = !ib_flush && (!wr_ok || !rd_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ib_err <= 1'b0;
    end else if (ib_flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ib_err <= 1'b0;
    end else begin
      head   <= head + AW'(rd_amt);
      tail   <= tail + AW'(wr_amt);
      count  <= count + CNT_WD'(wr_amt) - CNT_WD'(rd_amt);
      ib_err <= err_nxt;
    end
  end

  // Storage is deliberately not reset; entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (!ib_flush && wr_amt != 2'd0) begin
      mem[tail] <= ib_wr_line0;
      if (wr_amt == 2'd2)
        mem[tail + AW'(1)] <= ib_wr_line1;
    end
  end

  always_comb begin
    ib_rline0  = mem[head];
    ib_rline1  = mem[head + AW'(1)];
    ib_count   = count;
    ib_rvalid0 = (count >= CNT_WD'(1));
    ib_rvalid1 = (count >= CNT_WD'(2));
    ib_empty   = (count == '0);
    ib_full    = (count == CNT_WD'(DEPTH));
    ib_afull   = (free_slots < CNT_WD'(2));
  end

endmodule
